vga_mem_arbiter: RTL and testbench

- Shares the single-port 32-bit data memory between the CPU data port and the VGA image scan-out path.
- Prefetches image pixels (low byte of each word, grayscale) sequentially from IMG_BASE into a small FIFO, so the display side can pop one pixel per active pixel inside the IMG_W x IMG_H window.
- Sits between the processor, data memory and the VGA pixel-colour stage.

---
 rtl/vga_pkg.sv | 15 +
 rtl/vga_mem_arbiter_pixel_fifo.sv | 60 ++++++
 rtl/vga_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_vga_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and default image geometry for the VGA / CPU memory arbiter.
package vga_pkg;

  localparam int unsigned IMG_W_DEF = 400;
  localparam int unsigned IMG_H_DEF = 400;

  // Owner of the single read that may be in flight in the memory.
  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_CPU,
    OWN_VID,
    OWN_VID_DROP
  } owner_t;

endpackage

// File: rtl/vga_mem_arbiter_pixel_fifo.sv
// Synchronous 8-bit pixel FIFO; flush overrides push and pop, empty head reads as 0.
module pixel_fifo #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    data,
  output logic [LW-1:0] level,
  output logic          empty,
  output logic          full
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign level   = count;
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is accepted when a pop frees the slot in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign data    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + LW'(1);
      end else if (!do_push && do_pop) begin
        count <= count - LW'(1);
      end
    end
  end

endmodule

// File: rtl/vga_mem_arbiter.sv
// Shares one single-port data memory between the CPU data port and the
// sequential VGA pixel prefetch, buffering pixels in a small FIFO.
module vga_mem_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned IMG_BASE   = 0,
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LOW_WM     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame_start,
  input  logic          pix_pop,
  output logic [7:0]    pix_data,
  output logic          pix_valid,
  output logic          underflow,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [31:0]   cpu_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned CW    = $clog2(TOTAL + 1);
  localparam int unsigned LW    = $clog2(FIFO_DEPTH) + 1;

  owner_t        owner_q;
  owner_t        owner_d;
  owner_t        owner_eff;
  logic [AW-1:0] fetch_ptr;
  logic [CW-1:0] fetch_cnt;
  logic [LW-1:0] fifo_level;
  logic [LW:0]   occupancy;
  logic [7:0]    fifo_data;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_push;
  logic          fifo_pop;
  logic          vid_inflight;
  logic          vid_want;
  logic          urgent;
  logic          gnt_cpu;
  logic          gnt_vid;
  logic          underflow_q;

  // A video read returning in a frame_start cycle belongs to the old frame.
  assign owner_eff    = (owner_q == OWN_VID && frame_start) ? OWN_VID_DROP : owner_q;
  assign vid_inflight = (owner_q == OWN_VID);
  assign occupancy    = {1'b0, fifo_level} + (LW + 1)'(vid_inflight);
  assign urgent       = (fifo_level <= LW'(LOW_WM));
  // No new fetch in a frame_start cycle: the pointer is being rewound.
  assign vid_want     = !frame_start && !fifo_full
                        && (fetch_cnt < CW'(TOTAL))
                        && (occupancy < (LW + 1)'(FIFO_DEPTH));

  always_comb begin
    gnt_cpu   = 1'b0;
    gnt_vid   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    owner_d   = OWN_NONE;
    if (!reset) begin
      if (vid_want && urgent) begin
        gnt_vid = 1'b1;
      end else if (cpu_req) begin
        gnt_cpu = 1'b1;
      end else if (vid_want) begin
        gnt_vid = 1'b1;
      end
    end
    if (gnt_cpu) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      if (!cpu_we) begin
        owner_d = OWN_CPU;
      end
    end else if (gnt_vid) begin
      mem_en   = 1'b1;
      mem_addr = fetch_ptr;
      owner_d  = OWN_VID;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= OWN_NONE;
    end else begin
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || frame_start) begin
      fetch_ptr <= AW'(IMG_BASE);
      fetch_cnt <= '0;
    end else if (gnt_vid) begin
      fetch_ptr <= fetch_ptr + AW'(1);
      fetch_cnt <= fetch_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (pix_pop && fifo_empty && !frame_start) begin
      underflow_q <= 1'b1;
    end
  end

  assign fifo_push  = !reset && (owner_eff == OWN_VID);
  assign fifo_pop   = pix_pop && !fifo_empty && !frame_start;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .push      (fifo_push),
    .push_data (mem_rdata[7:0]),
    .pop       (fifo_pop),
    .data      (fifo_data),
    .level     (fifo_level),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign cpu_gnt    = gnt_cpu;
  assign cpu_rvalid = !reset && (owner_eff == OWN_CPU);
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
  assign pix_valid  = !fifo_empty;
  assign pix_data   = fifo_data;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed scoreboard bench for vga_mem_arbiter on a 4x2 image with a modelled memory.
module tb_vga_mem_arbiter;

  localparam int unsigned AW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_pop = 1'b0;
  logic [7:0]    pix_data;
  logic          pix_valid;
  logic          underflow;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [31:0]   cpu_wdata = '0;
  logic          cpu_gnt;
  logic          cpu_rvalid;
  logic [31:0]   cpu_rdata;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic [31:0]   mem [512];
  logic [7:0]    exp_pix [$];
  logic [31:0]   exp_cpu [$];
  int            tests = 0;
  int            fails = 0;
  int            waited;

  vga_mem_arbiter #(
    .AW         (AW),
    .IMG_BASE   (0),
    .IMG_W      (4),
    .IMG_H      (2),
    .FIFO_DEPTH (8),
    .LOW_WM     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .pix_pop     (pix_pop),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: word k holds k, word 0x100 holds 0xDEADBEEF; reloaded on reset.
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 512; k++) begin
        mem[k] <= (k == 256) ? 32'hDEADBEEF : 32'(k);
      end
      mem_rdata <= '0;
    end else if (mem_en) begin
      if (mem_we) begin
        mem[mem_addr[8:0]] <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_addr[8:0]];
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_underflow"}, 32'(underflow), 32'd0);
    check({tag, "_cpu_gnt"}, 32'(cpu_gnt), 32'd0);
    check({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
    check({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    check({tag, "_mem_en"}, 32'(mem_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic push_frame(input logic [7:0] p3);
    for (int i = 0; i < 8; i++) begin
      exp_pix.push_back((i == 3) ? p3 : 8'(i));
    end
  endtask

  task automatic pulse_frame();
    @(negedge clk);
    frame_start = 1'b1;
    @(posedge clk);
    #1 frame_start = 1'b0;
  endtask

  task automatic pop_checked(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      e = exp_pix.pop_front();
      check("pop_pix_valid", 32'(pix_valid), 32'd1);
      check("pop_pix_data", 32'(pix_data), 32'(e));
      pix_pop = 1'b1;
      @(posedge clk);
      #1 pix_pop = 1'b0;
    end
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [31:0] wd,
                            input logic [31:0] rexp, output int nwait);
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = wd;
    #1;
    nwait = 0;
    while (!cpu_gnt && nwait < 50) begin
      @(negedge clk);
      #1;
      nwait++;
    end
    check("cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("cpu_mem_addr", 32'(mem_addr), 32'(a));
    check("cpu_mem_we", 32'(mem_we), 32'(we));
    if (!we) begin
      exp_cpu.push_back(rexp);
    end
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    if (!we) begin
      @(negedge clk);
      check("cpu_rvalid", 32'(cpu_rvalid), 32'd1);
      check("cpu_rdata", cpu_rdata, exp_cpu.pop_front());
    end
  endtask

  task automatic wait_vid(input logic [AW-1:0] a, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_en && !mem_we && mem_addr == a) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(mem_en && !mem_we && mem_addr == a), 32'd1);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");

    // Fill after reset: fetch starts at IMG_BASE, stops at 8 pixels
    reset = 1'b0;
    push_frame(8'd3);
    #1;
    check("first_fetch_en", 32'(mem_en), 32'd1);
    check("first_fetch_addr", 32'(mem_addr), 32'd0);
    repeat (20) @(negedge clk);
    check("fill_pix_valid", 32'(pix_valid), 32'd1);
    check("fill_pix_data", 32'(pix_data), 32'd0);
    check("fill_stopped", 32'(mem_en), 32'd0);

    // Drain, then one pop on empty
    pop_checked(8);
    @(negedge clk);
    check("drain_pix_valid", 32'(pix_valid), 32'd0);
    check("drain_underflow", 32'(underflow), 32'd0);
    pix_pop = 1'b1;
    @(posedge clk);
    #1 pix_pop = 1'b0;
    @(negedge clk);
    check("underflow_set", 32'(underflow), 32'd1);
    check("underflow_pix_data", 32'(pix_data), 32'd0);
    check("underflow_pix_valid", 32'(pix_valid), 32'd0);

    // CPU write to image word 3, visible in next frame
    cpu_access(1'b1, 16'h0003, 32'h0000_0055, 32'd0, waited);
    check("wr_wait", 32'(waited), 32'd0);
    pulse_frame();
    push_frame(8'h55);
    repeat (20) @(negedge clk);
    check("refill_stopped", 32'(mem_en), 32'd0);
    pop_checked(3);

    // CPU read with FIFO level 5: granted immediately
    cpu_access(1'b0, 16'h0100, 32'd0, 32'hDEADBEEF, waited);
    check("rd_level5_wait", 32'(waited), 32'd0);
    pop_checked(5);

    // CPU read with FIFO level 2 while video wants: video first
    pulse_frame();
    wait_vid(16'h0003, "vid_addr3");
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0100;
    #1;
    check("urgent_cpu_gnt", 32'(cpu_gnt), 32'd0);
    check("urgent_vid_addr", 32'(mem_addr), 32'd3);
    @(negedge clk);
    check("late_cpu_gnt", 32'(cpu_gnt), 32'd1);
    check("late_cpu_addr", 32'(mem_addr), 32'h0100);
    exp_cpu.push_back(32'hDEADBEEF);
    @(posedge clk);
    #1 cpu_req = 1'b0;
    @(negedge clk);
    check("late_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
    check("late_cpu_rdata", cpu_rdata, exp_cpu.pop_front());

    // frame_start the cycle after a video grant: returning word dropped
    pulse_frame();
    wait_vid(16'h0000, "vid_addr0");
    @(negedge clk);
    frame_start = 1'b1;
    #1;
    check("fs_no_grant", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 frame_start = 1'b0;
    @(negedge clk);
    check("drop_pix_valid", 32'(pix_valid), 32'd0);
    check("drop_restart_en", 32'(mem_en), 32'd1);
    check("drop_restart_addr", 32'(mem_addr), 32'd0);
    check("underflow_sticky", 32'(underflow), 32'd1);
    push_frame(8'h55);
    repeat (20) @(negedge clk);
    pop_checked(8);
    @(negedge clk);
    check("refetch_pix_valid", 32'(pix_valid), 32'd0);

    // Reset the cycle after a CPU read grant
    @(negedge clk);
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 16'h0100;
    #1;
    check("rst_cpu_gnt", 32'(cpu_gnt), 32'd1);
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("post_reset");
    reset = 1'b0;
    #1;
    check("release_cpu_rvalid", 32'(cpu_rvalid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
